rotl_barrel_pipe: RTL and testbench
===================================

// Module: rotl_barrel_pipe
// PURPOSE
//   Pipelined left-rotate barrel shifter; inverse of the 8-bit right-rotate barrel unit.
//   Data rotated right by s and passed through this block with the same s returns unchanged.
//   Sits on the return path of the datapath with a valid/ready stream on both sides.
//   Rotation is split log2(WIDTH) ways; stage k rotates left by 2**k when shamt[k]=1.
//   Each stage is registered.
// PARAMETERS
//   WIDTH  8  data width; power of two, >= 2
//   SHW    $clog2(WIDTH) = 3  shift-amount width = stage count; derived, do not override
// PORTS
//   clk        in   1      rising-edge clock; single clock domain
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      upstream word/amount valid
//   in_ready   out  1      block can accept this cycle
//   in_data    in   WIDTH  word to rotate
//   in_shamt   in   SHW    left-rotate amount, 0..WIDTH-1
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_data   out  WIDTH  in_data rotated left by in_shamt
//   out_shamt  out  SHW    in_shamt carried alongside, for checking and chaining
// BEHAVIOUR
//   - Reset (rst_n=0, async): all stage valids=0 and all stage data/shamt regs=0.
//     Outputs during reset: out_valid=0, out_data=0, out_shamt=0, in_ready=1.
//   - Transfer occurs when valid&&ready on that edge, on each side.
//   - Stage k (k=0..SHW-1) has regs v_k, d_k, s_k.
//     ready_k = !v_k || ready_(k+1); ready_SHW = out_ready; in_ready = ready_0.
//   - On an edge where ready_k=1: v_k <= v_(k-1) (v_-1 = in_valid).
//     d_k <= s[k] ? {d[W-1-2**k:0], d[W-1:W-2**k]} : d; s_k <= s.
//     The d and s on the right are those of the previous stage.
//   - On an edge where ready_k=0, stage k holds all of its regs.
//   - out_* are driven straight from the last stage. No combinational path from in_data to out_data.
//   - Latency is SHW cycles from input accept to out_valid when out_ready stays 1 (3 cycles at WIDTH=8).
//     Throughput is 1 word per cycle.
//   - Capacity is SHW words. With out_ready=0, the pipe fills and then in_ready drops.
//     in_ready rises in the same cycle that out_ready rises (combinational ready chain).
//   - While out_valid=1 && out_ready=0, out_data and out_shamt are held stable.
//   - Bubbles collapse: an empty stage accepts even when downstream is stalled.
//   - shamt=0 passes data unchanged. Wrap-around is inherent; the amount is modulo WIDTH by width.
//   - Payload regs with v_k=0 are don't-care except at reset.
//   - A reset mid-operation discards all words in flight. No output handshake follows for them.
// CONFIGURATION
//   ROT_DIR_SEL_EN defined:
//     - Adds port in_dir (in, 1); it travels with the word the same way shamt does.
//     - Per stage, dir=1 rotates right by 2**k and dir=0 rotates left.
//     - Adds out_dir (out, 1); reset value 0.
//   ROT_DIR_SEL_EN undefined:
//     - No dir ports; left rotate only.
//     - Logic is identical to the dir=0 case.
// STRUCTURE
//   - Package rot_pkg: ROT_WIDTH=8 and ROT_SHW=3 localparams.
//   - Also in rot_pkg: function rotl(d,n) and rotr(d,n), used by both RTL and bench.
//   - Sub-module rot_stage (params WIDTH, STEP=2**k):
//     one registered stage with valid/ready, rotate mux and shamt/dir passthrough.
//   - Top level instantiates SHW copies with a generate loop and chains ready backwards.
// TESTING
//   1 Reset: hold rst_n=0 with in_valid=1.
//     -> out_valid=0, out_data=0, in_ready=1. No transfer after release until in_valid is sampled.
//   2 Single word: in_data=8'hB4, shamt=1, out_ready=1.
//     -> out_data=8'h69 exactly 3 cycles after accept.
//     -> shamt=5 gives 8'h96; shamt=0 gives 8'hB4.
//   3 Streaming: 256 words back-to-back with random data and shamt, out_ready=1.
//     -> one result per cycle, in order; each equals rotl(d,s) and out_shamt=s.
//   4 Backpressure: out_ready=0 while offering 5 words.
//     -> exactly 3 accepted, then in_ready=0; out_data is stable while stalled.
//     -> raise out_ready: all 5 words emerge in order; none lost or duplicated.
//   5 Round trip: feed the right-rotate unit's output (d, s) into this block with the same s.
//     -> out_data==d for all 256x8 (d,s) pairs.
//   6 Mid-flight reset: assert rst_n=0 with 3 words in flight.
//     -> out_valid=0 immediately (async); after release, no stale word appears.
//   ROT_DIR_SEL_EN build: in_data=8'hB4, shamt=1, dir=1 -> out_data=8'h5A.
//     -> Rerun scenario 3 with random dir.

Source files
------------

// File: rtl/rot_pkg.sv
// rot_pkg: shared widths and reference rotate helpers for the rotl_barrel_pipe slice.
package rot_pkg;
   localparam int ROT_WIDTH = 8;
   localparam int ROT_SHW = $clog2(ROT_WIDTH);
   function automatic logic [ROT_WIDTH-1:0] rotl(input logic [ROT_WIDTH-1:0] d, input logic [ROT_SHW-1:0] n);
      return (d << n) | (d >> (ROT_WIDTH - int'(n)));
   endfunction
   function automatic logic [ROT_WIDTH-1:0] rotr(input logic [ROT_WIDTH-1:0] d, input logic [ROT_SHW-1:0] n);
      return (d >> n) | (d << (ROT_WIDTH - int'(n)));
   endfunction
endpackage

// File: rtl/rot_stage.sv
// rot_stage: one registered rotate-by-STEP stage; ROT_DIR_SEL_EN adds a per-word direction bit.
module rot_stage
   import rot_pkg::*;
#(
   parameter int WIDTH = ROT_WIDTH,
   parameter int STEP = 1,
   parameter int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ready,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
`ifdef ROT_DIR_SEL_EN
   input  logic             in_dir,
   output logic             out_dir,
`endif
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [SHW-1:0]   out_shamt
);
   localparam int K = $clog2(STEP);
   logic [WIDTH-1:0] lrot, nxt;
   assign lrot = {in_data[WIDTH-1-STEP:0], in_data[WIDTH-1:WIDTH-STEP]};
`ifdef ROT_DIR_SEL_EN
   logic [WIDTH-1:0] rrot;
   assign rrot = {in_data[STEP-1:0], in_data[WIDTH-1:STEP]};
   assign nxt = !in_shamt[K] ? in_data : in_dir ? rrot : lrot;
`else
   assign nxt = in_shamt[K] ? lrot : in_data;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data <= '0;
         out_shamt <= '0;
`ifdef ROT_DIR_SEL_EN
         out_dir <= 1'b0;
`endif
      end else if (ready) begin
         out_valid <= in_valid;
         out_data <= nxt;
         out_shamt <= in_shamt;
`ifdef ROT_DIR_SEL_EN
         out_dir <= in_dir;
`endif
      end
   end
endmodule

// File: rtl/rotl_barrel_pipe.sv
// rotl_barrel_pipe: pipelined left-rotate barrel shifter with valid/ready; ROT_DIR_SEL_EN adds in_dir/out_dir.
module rotl_barrel_pipe
   import rot_pkg::*;
#(
   parameter int WIDTH = ROT_WIDTH,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
`ifdef ROT_DIR_SEL_EN
   input  logic             in_dir,
   output logic             out_dir,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [SHW-1:0]   out_shamt
);
   logic [SHW:0] v, rdy;
   logic [WIDTH-1:0] d [SHW+1];
   logic [SHW-1:0] s [SHW+1];
   assign v[0] = in_valid;
   assign d[0] = in_data;
   assign s[0] = in_shamt;
   assign rdy[SHW] = out_ready;
`ifdef ROT_DIR_SEL_EN
   logic [SHW:0] dir;
   assign dir[0] = in_dir;
   assign out_dir = dir[SHW];
`endif
   for (genvar k = 0; k < SHW; k++) begin : g
      // ready_k = !v_k || ready_(k+1), unrolled so it depends only on registered valids
      assign rdy[k] = out_ready || !(&v[SHW:k+1]);
      rot_stage #(.WIDTH(WIDTH), .STEP(2**k), .SHW(SHW)) u_stage (
         .clk(clk),
         .rst_n(rst_n),
         .ready(rdy[k]),
         .in_valid(v[k]),
         .in_data(d[k]),
         .in_shamt(s[k]),
`ifdef ROT_DIR_SEL_EN
         .in_dir(dir[k]),
         .out_dir(dir[k+1]),
`endif
         .out_valid(v[k+1]),
         .out_data(d[k+1]),
         .out_shamt(s[k+1])
      );
   end
   assign in_ready = rdy[0];
   assign out_valid = v[SHW];
   assign out_data = d[SHW];
   assign out_shamt = s[SHW];
endmodule

// File: tb/tb_rotl_barrel_pipe.sv
// tb_rotl_barrel_pipe: directed self-checking bench; define ROT_DIR_SEL_EN to cover the direction build.
module tb_rotl_barrel_pipe;
   import rot_pkg::*;
   typedef struct {
      logic [7:0] d;
      logic [2:0] s;
      logic       dir;
      int         cyc;
   } item_t;
   logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, in_dir = 0;
   logic [7:0] in_data = 0;
   logic [2:0] in_shamt = 0;
   logic in_ready, out_valid, odir;
   logic [7:0] out_data;
   logic [2:0] out_shamt;
   int errs = 0, checks = 0, cyc = 0;
   item_t in_q[$], out_q[$];

   always #5 clk = ~clk;

`ifdef ROT_DIR_SEL_EN
   logic out_dir;
   assign odir = out_dir;
`else
   assign odir = 1'b0;
`endif

   rotl_barrel_pipe dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_shamt(in_shamt),
`ifdef ROT_DIR_SEL_EN
      .in_dir(in_dir),
      .out_dir(out_dir),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_shamt(out_shamt)
   );

   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) in_q.push_back('{in_data, in_shamt, in_dir, cyc});
      if (rst_n && out_valid && out_ready) out_q.push_back('{out_data, out_shamt, odir, cyc});
      cyc++;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_one(input logic [7:0] dd, input logic [2:0] ss, input logic dr);
      bit done = 0;
      in_valid = 1; in_data = dd; in_shamt = ss; in_dir = dr;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 0; in_dir = 0;
      checks++;
      if (!done) begin errs++; $display("FAIL send_one accept: in_ready stayed 0, required 1 within 20 cycles"); end
   endtask

   task automatic test_reset;
      rst_n = 0; in_valid = 1; in_data = 8'hFF; in_shamt = 3'd3; out_ready = 1;
      tick(3);
      checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset out_valid: got %b need 0", out_valid); end
      checks++; if (out_data !== 8'h00) begin errs++; $display("FAIL reset out_data: got %h need 00", out_data); end
      checks++; if (out_shamt !== 3'd0) begin errs++; $display("FAIL reset out_shamt: got %0d need 0", out_shamt); end
      checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset in_ready: got %b need 1", in_ready); end
      checks++; if (odir !== 1'b0) begin errs++; $display("FAIL reset out_dir: got %b need 0", odir); end
      in_valid = 0;
      rst_n = 1;
      tick(5);
      checks++;
      if (out_valid !== 1'b0 || in_q.size() != 0 || out_q.size() != 0) begin
         errs++;
         $display("FAIL reset release: out_valid=%b accepts=%0d outputs=%0d, need 0/0/0", out_valid, in_q.size(), out_q.size());
      end
   endtask

   task automatic test_single;
      logic [2:0] vs [3] = '{3'd1, 3'd5, 3'd0};
      logic [7:0] ve [3] = '{8'h69, 8'h96, 8'hB4};
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         in_q.delete(); out_q.delete();
         send_one(8'hB4, vs[i], 1'b0);
         for (int c = 0; c < 10 && out_q.size() == 0; c++) tick();
         checks++;
         if (out_q.size() != 1 || in_q.size() != 1) begin
            errs++;
            $display("FAIL single count shamt=%0d: outputs=%0d accepts=%0d, need 1/1", vs[i], out_q.size(), in_q.size());
         end else begin
            checks++; if (out_q[0].d !== ve[i]) begin errs++; $display("FAIL single data shamt=%0d: got %h need %h", vs[i], out_q[0].d, ve[i]); end
            checks++; if (out_q[0].s !== vs[i]) begin errs++; $display("FAIL single shamt: got %0d need %0d", out_q[0].s, vs[i]); end
            checks++;
            if (out_q[0].cyc - in_q[0].cyc != 3) begin
               errs++;
               $display("FAIL single latency shamt=%0d: got %0d need 3", vs[i], out_q[0].cyc - in_q[0].cyc);
            end
         end
      end
   endtask

   task automatic test_stream(input bit rnd_dir);
      logic [7:0] e;
      int bad = 0;
      in_q.delete(); out_q.delete(); out_ready = 1;
      for (int i = 0; i < 256; i++) begin
         in_valid = 1; in_data = 8'($urandom); in_shamt = 3'($urandom);
         in_dir = rnd_dir ? 1'($urandom) : 1'b0;
         tick();
      end
      in_valid = 0; in_dir = 0;
      tick(6);
      checks++;
      if (in_q.size() != 256 || out_q.size() != 256) begin
         errs++;
         $display("FAIL stream count dir=%0d: accepts=%0d outputs=%0d, need 256/256", rnd_dir, in_q.size(), out_q.size());
      end else begin
         checks++;
         if (out_q[255].cyc - out_q[0].cyc != 255 || in_q[255].cyc - in_q[0].cyc != 255) begin
            errs++;
            $display("FAIL stream throughput: out span %0d in span %0d, need 255", out_q[255].cyc - out_q[0].cyc, in_q[255].cyc - in_q[0].cyc);
         end
         for (int i = 0; i < 256; i++) begin
            e = in_q[i].dir ? rotr(in_q[i].d, in_q[i].s) : rotl(in_q[i].d, in_q[i].s);
            checks++;
            if (out_q[i].d !== e || out_q[i].s !== in_q[i].s || out_q[i].dir !== in_q[i].dir) begin
               errs++;
               if (bad++ < 5)
                  $display("FAIL stream word %0d: got %h/%0d/%b need %h/%0d/%b", i, out_q[i].d, out_q[i].s, out_q[i].dir, e, in_q[i].s, in_q[i].dir);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      logic [7:0] bd [5] = '{8'h01, 8'h80, 8'hF0, 8'h3C, 8'hA5};
      logic [2:0] bs [5] = '{3'd3, 3'd1, 3'd4, 3'd2, 3'd7};
      logic [7:0] be [5] = '{8'h08, 8'h01, 8'h0F, 8'hF0, 8'hD2};
      logic [7:0] held;
      int n = 0;
      in_q.delete(); out_q.delete(); out_ready = 0;
      for (int c = 0; c < 8; c++) begin
         in_valid = 1; in_data = bd[n]; in_shamt = bs[n];
         @(negedge clk);
         if (in_ready) n++;
         @(posedge clk);
         #1;
      end
      checks++; if (n != 3) begin errs++; $display("FAIL bp accepted while stalled: got %0d need 3", n); end
      checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp in_ready full: got %b need 0", in_ready); end
      checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp out_valid full: got %b need 1", out_valid); end
      held = out_data;
      checks++; if (held !== 8'h08) begin errs++; $display("FAIL bp head data: got %h need 08", held); end
      tick(2);
      checks++;
      if (out_data !== held || out_shamt !== 3'd3) begin
         errs++;
         $display("FAIL bp stable: got %h/%0d need %h/3", out_data, out_shamt, held);
      end
      out_ready = 1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp in_ready on out_ready rise: got %b need 1", in_ready); end
      for (int c = 0; c < 20 && n < 5; c++) begin
         in_valid = 1; in_data = bd[n]; in_shamt = bs[n];
         @(negedge clk);
         if (in_ready) n++;
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      tick(8);
      checks++;
      if (out_q.size() != 5) begin
         errs++;
         $display("FAIL bp drained count: got %0d need 5", out_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_q[i].d !== be[i] || out_q[i].s !== bs[i]) begin
               errs++;
               $display("FAIL bp word %0d: got %h/%0d need %h/%0d", i, out_q[i].d, out_q[i].s, be[i], bs[i]);
            end
         end
      end
   endtask

   task automatic test_round_trip;
      logic [7:0] exp_q[$];
      int bad = 0;
      in_q.delete(); out_q.delete(); out_ready = 1;
      for (int dd = 0; dd < 256; dd++)
         for (int ss = 0; ss < 8; ss++) begin
            in_valid = 1; in_shamt = 3'(ss);
            in_data = rotr(8'(dd), 3'(ss));
            exp_q.push_back(8'(dd));
            tick();
         end
      in_valid = 0;
      tick(6);
      checks++;
      if (out_q.size() != 2048) begin
         errs++;
         $display("FAIL round trip count: got %0d need 2048", out_q.size());
      end else begin
         for (int i = 0; i < 2048; i++) begin
            checks++;
            if (out_q[i].d !== exp_q[i]) begin
               errs++;
               if (bad++ < 5) $display("FAIL round trip word %0d: got %h need %h", i, out_q[i].d, exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_midflight_reset;
      logic [7:0] md [3] = '{8'h11, 8'h22, 8'h33};
      in_q.delete(); out_q.delete(); out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_data = md[i]; in_shamt = 3'(i + 1);
         tick();
      end
      in_valid = 0;
      checks++; if (in_q.size() != 3) begin errs++; $display("FAIL midreset accepts: got %0d need 3", in_q.size()); end
      checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL midreset in flight out_valid: got %b need 1", out_valid); end
      rst_n = 0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
         errs++;
         $display("FAIL midreset async: out_valid=%b out_data=%h in_ready=%b need 0/00/1", out_valid, out_data, in_ready);
      end
      tick(2);
      rst_n = 1;
      tick(6);
      checks++;
      if (out_q.size() != 0 || out_valid !== 1'b0) begin
         errs++;
         $display("FAIL midreset stale: outputs=%0d out_valid=%b need 0/0", out_q.size(), out_valid);
      end
   endtask

`ifdef ROT_DIR_SEL_EN
   task automatic test_dir;
      in_q.delete(); out_q.delete(); out_ready = 1;
      send_one(8'hB4, 3'd1, 1'b1);
      for (int c = 0; c < 10 && out_q.size() == 0; c++) tick();
      checks++;
      if (out_q.size() != 1) begin
         errs++;
         $display("FAIL dir count: got %0d need 1", out_q.size());
      end else begin
         checks++; if (out_q[0].d !== 8'h5A) begin errs++; $display("FAIL dir data: got %h need 5a", out_q[0].d); end
         checks++; if (out_q[0].dir !== 1'b1) begin errs++; $display("FAIL dir out_dir: got %b need 1", out_q[0].dir); end
      end
   endtask
`endif

   initial begin
      test_reset;
      test_single;
      test_stream(1'b0);
      test_backpressure;
      test_round_trip;
      test_midflight_reset;
`ifdef ROT_DIR_SEL_EN
      test_dir;
      test_stream(1'b1);
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
